// File: rtl/systolic_writeback_pkg.sv
// Shared definitions for the systolic array writeback path: accumulator
// width derivation, drain FSM states and output saturation bounds.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FLUSH,
    DONE
  } drain_state_t;

  // Width of one accumulator: full product, growth over the K sum, plus sign headroom
  function automatic int outcome_width(input int data_width, input int k_accum_depth);
    return 2 * data_width + ((k_accum_depth == 1) ? 0 : $clog2(k_accum_depth)) + 1;
  endfunction

  function automatic int sat_max(input int data_width);
    return (1 << (data_width - 1)) - 1;
  endfunction

  function automatic int sat_min(input int data_width);
    return -(1 << (data_width - 1));
  endfunction

endpackage

// File: rtl/systolic_writeback_lane.sv
// One requantization lane: round-half-up arithmetic shift, optional ReLU,
// then saturation to the signed output width. Purely combinational.
module requant_lane
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int OUTCOME_WIDTH = 20
) (
  input  logic [OUTCOME_WIDTH-1:0] acc,
  input  logic [4:0]               quant_shift,
  input  logic                     relu_en,
  output logic [DATA_WIDTH-1:0]    result,
  output logic                     sat
);

  // One extra bit so the rounding add can never overflow
  localparam int EXT_WIDTH = OUTCOME_WIDTH + 1;
  localparam logic signed [EXT_WIDTH-1:0] MAX_VAL = EXT_WIDTH'(sat_max(DATA_WIDTH));
  localparam logic signed [EXT_WIDTH-1:0] MIN_VAL = EXT_WIDTH'(sat_min(DATA_WIDTH));

  logic [4:0]                  shift_eff;
  logic signed [EXT_WIDTH-1:0] acc_ext;
  logic signed [EXT_WIDTH-1:0] rounded;
  logic signed [EXT_WIDTH-1:0] shifted;

  // Clamp the shift, round, shift, rectify and saturate one element
  always_comb begin
    shift_eff = quant_shift;
    if (int'(quant_shift) > OUTCOME_WIDTH - 1) begin
      shift_eff = 5'(OUTCOME_WIDTH - 1);
    end
    acc_ext = {acc[OUTCOME_WIDTH-1], acc};
    rounded = acc_ext;
    if (shift_eff != 5'd0) begin
      rounded = acc_ext + (EXT_WIDTH'(1) << (shift_eff - 5'd1));
    end
    shifted = rounded >>> shift_eff;
    if (relu_en && (shifted < 0)) begin
      shifted = '0;
    end
    sat    = 1'b0;
    result = shifted[DATA_WIDTH-1:0];
    if (shifted > MAX_VAL) begin
      result = MAX_VAL[DATA_WIDTH-1:0];
      sat    = 1'b1;
    end else if (shifted < MIN_VAL) begin
      result = MIN_VAL[DATA_WIDTH-1:0];
      sat    = 1'b1;
    end
  end

endmodule

// File: rtl/systolic_writeback.sv
// Drains a finished tile from the systolic array row by row, requantizes
// every row through ARRAY_SIZE lanes and writes it as one packed SRAM word.
module systolic_writeback
  import systolic_pkg::*;
#(
  parameter int  ARRAY_SIZE    = 8,
  parameter int  DATA_WIDTH    = 8,
  parameter int  K_ACCUM_DEPTH = 8,
  parameter int  ADDR_WIDTH    = 10,
  localparam int OUTCOME_WIDTH = outcome_width(DATA_WIDTH, K_ACCUM_DEPTH)
) (
  input  logic                             clk,
  input  logic                             srstn,
  input  logic                             drain_start,
  input  logic [ADDR_WIDTH-1:0]            base_addr,
  input  logic [4:0]                       quant_shift,
  input  logic                             relu_en,
  input  logic [ARRAY_SIZE*OUTCOME_WIDTH-1:0] mul_outcome,
  output logic [5:0]                       matrix_index,
  output logic                             sram_wen,
  output logic [ADDR_WIDTH-1:0]            sram_waddr,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] sram_wdata,
  output logic                             drain_busy,
  output logic                             drain_done,
  output logic                             sat_flag
);

  localparam logic [5:0] LAST_ROW = 6'(ARRAY_SIZE - 1);

  drain_state_t state, state_next;

  logic [ADDR_WIDTH-1:0]            base_q;
  logic [4:0]                       shift_q;
  logic                             relu_q;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] lane_data;
  logic [ARRAY_SIZE-1:0]            lane_sat;
  logic                             accept;
  logic                             last_row;

  assign accept   = (state == IDLE) && drain_start;
  assign last_row = (matrix_index == LAST_ROW);

  for (genvar j = 0; j < ARRAY_SIZE; j++) begin : g_lane
    requant_lane #(
      .DATA_WIDTH   (DATA_WIDTH),
      .OUTCOME_WIDTH(OUTCOME_WIDTH)
    ) u_lane (
      .acc        (mul_outcome[j*OUTCOME_WIDTH +: OUTCOME_WIDTH]),
      .quant_shift(shift_q),
      .relu_en    (relu_q),
      .result     (lane_data[j*DATA_WIDTH +: DATA_WIDTH]),
      .sat        (lane_sat[j])
    );
  end

  // FSM state register
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; starts outside IDLE (including DONE) are dropped
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (drain_start) state_next = DRAIN;
      DRAIN:   if (last_row) state_next = FLUSH;
      FLUSH:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Drain parameters are frozen for the whole tile once a start is taken
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      base_q  <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
    end else if (accept) begin
      base_q  <= base_addr;
      shift_q <= quant_shift;
      relu_q  <= relu_en;
    end
  end

  // Registered outputs: row select, write port, status and sticky saturation
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      matrix_index <= '0;
      sram_wen     <= 1'b0;
      sram_waddr   <= '0;
      sram_wdata   <= '0;
      drain_busy   <= 1'b0;
      drain_done   <= 1'b0;
      sat_flag     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sram_wen   <= 1'b0;
          drain_done <= 1'b0;
          if (drain_start) begin
            matrix_index <= '0;
            sat_flag     <= 1'b0;
            drain_busy   <= 1'b1;
          end
        end
        DRAIN: begin
          sram_wen     <= 1'b1;
          sram_waddr   <= base_q + ADDR_WIDTH'(matrix_index);
          sram_wdata   <= lane_data;
          matrix_index <= last_row ? 6'd0 : matrix_index + 6'd1;
          if (|lane_sat) begin
            sat_flag <= 1'b1;
          end
        end
        FLUSH: begin
          sram_wen   <= 1'b0;
          drain_busy <= 1'b0;
          drain_done <= 1'b1;
        end
        DONE: begin
          drain_done <= 1'b0;
        end
        default: begin
          sram_wen   <= 1'b0;
          drain_busy <= 1'b0;
          drain_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_writeback.sv
// Self-checking bench for systolic_writeback: table-driven requantization
// vectors, cycle-exact timing of a wrapping drain with ignored starts, and
// an asynchronous reset in the middle of a drain.
module tb_systolic_writeback;

  localparam int AS = 8;
  localparam int DW = 8;
  localparam int OW = 20;
  localparam int AW = 10;

  logic              clk;
  logic              srstn;
  logic              drain_start;
  logic [AW-1:0]     base_addr;
  logic [4:0]        quant_shift;
  logic              relu_en;
  logic [AS*OW-1:0]  mul_outcome;
  logic [5:0]        matrix_index;
  logic              sram_wen;
  logic [AW-1:0]     sram_waddr;
  logic [AS*DW-1:0]  sram_wdata;
  logic              drain_busy;
  logic              drain_done;
  logic              sat_flag;

  systolic_writeback dut (
    .clk         (clk),
    .srstn       (srstn),
    .drain_start (drain_start),
    .base_addr   (base_addr),
    .quant_shift (quant_shift),
    .relu_en     (relu_en),
    .mul_outcome (mul_outcome),
    .matrix_index(matrix_index),
    .sram_wen    (sram_wen),
    .sram_waddr  (sram_waddr),
    .sram_wdata  (sram_wdata),
    .drain_busy  (drain_busy),
    .drain_done  (drain_done),
    .sat_flag    (sat_flag)
  );

  typedef struct {
    int   shift;
    bit   relu;
    int   a[4];
    int   e[4];
    bit   esat;
  } vec_t;

  typedef struct {
    logic [AW-1:0]    addr;
    logic [AS*DW-1:0] data;
  } wr_t;

  int  tile_in[AS][AS];
  int  tile_exp[AS][AS];
  wr_t sb[$];
  int  n_compared = 0;
  int  n_failed   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the array: the row picked by matrix_index, combinationally
  always_comb begin
    mul_outcome = '0;
    if (matrix_index < 6'(AS)) begin
      for (int c = 0; c < AS; c++) begin
        mul_outcome[c*OW +: OW] = OW'(tile_in[matrix_index[2:0]][c]);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every SRAM write must match the oldest pending expectation
  always @(negedge clk) begin
    if (sram_wen === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_write", 64'(sram_waddr), 64'hFFFF);
      end else begin
        wr_t w;
        w = sb.pop_front();
        checkOutput("write_addr", 64'(sram_waddr), 64'(w.addr));
        checkOutput("write_data", 64'(sram_wdata), 64'(w.data));
      end
    end
  end

  task automatic clear_tile();
    for (int r = 0; r < AS; r++)
      for (int c = 0; c < AS; c++) begin
        tile_in[r][c]  = 0;
        tile_exp[r][c] = 0;
      end
  endtask

  task automatic push_expected(input int base);
    for (int r = 0; r < AS; r++) begin
      wr_t w;
      w.addr = AW'(base + r);
      for (int c = 0; c < AS; c++) w.data[c*DW +: DW] = DW'(tile_exp[r][c]);
      sb.push_back(w);
    end
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_index"}, 64'(matrix_index), 64'd0);
    checkOutput({tag, "_wen"},   64'(sram_wen),     64'd0);
    checkOutput({tag, "_waddr"}, 64'(sram_waddr),   64'd0);
    checkOutput({tag, "_wdata"}, 64'(sram_wdata),   64'd0);
    checkOutput({tag, "_busy"},  64'(drain_busy),   64'd0);
    checkOutput({tag, "_done"},  64'(drain_done),   64'd0);
    checkOutput({tag, "_sat"},   64'(sat_flag),     64'd0);
  endtask

  // Run one full drain with cycle-exact checks; optional stray starts in cycles 3 and 10
  task automatic applyStimulus(input int base, input int shift, input bit relu,
                               input bit exp_sat, input bit extra);
    push_expected(base);
    @(posedge clk); #1;
    base_addr   = AW'(base);
    quant_shift = 5'(shift);
    relu_en     = relu;
    drain_start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      drain_start = extra && (c == 3 || c == 10);
      if (c == 1) begin
        base_addr   = ~AW'(base);
        quant_shift = 5'd7;
        relu_en     = ~relu;
      end
      @(negedge clk);
      if (c <= AS) checkOutput("matrix_index", 64'(matrix_index), 64'(c - 1));
      checkOutput("sram_wen",   64'(sram_wen),   64'(c >= 2 && c <= 9));
      checkOutput("drain_busy", 64'(drain_busy), 64'(c <= 9));
      checkOutput("drain_done", 64'(drain_done), 64'(c == 10));
      if (c == 1)  checkOutput("sat_cleared", 64'(sat_flag), 64'd0);
      if (c == 10) checkOutput("sat_flag",    64'(sat_flag), 64'(exp_sat));
    end
    checkOutput("writes_pending", 64'(sb.size()), 64'd0);
  endtask

  vec_t vecs[8];

  initial begin
    bit seen_wen;
    bit seen_done;

    vecs[0] = '{shift: 0,  relu: 0, a: '{100, 300, -300, 0},     e: '{100, 127, -128, 0}, esat: 1};
    vecs[1] = '{shift: 4,  relu: 0, a: '{40, -40, 8, -8},        e: '{3, -2, 1, 0},       esat: 0};
    vecs[2] = '{shift: 0,  relu: 1, a: '{-5, 5, 0, 0},           e: '{0, 5, 0, 0},        esat: 0};
    vecs[3] = '{shift: 31, relu: 0, a: '{524287, -524288, 0, 1}, e: '{1, -1, 0, 0},       esat: 0};
    vecs[4] = '{shift: 1,  relu: 0, a: '{3, -3, -2, 255},        e: '{2, -1, -1, 127},    esat: 1};
    vecs[5] = '{shift: 0,  relu: 1, a: '{-1000, 1000, -1, 127},  e: '{0, 127, 0, 127},    esat: 1};
    vecs[6] = '{shift: 2,  relu: 1, a: '{-6, 600, -2, 5},        e: '{0, 127, 0, 1},      esat: 1};
    vecs[7] = '{shift: 3,  relu: 0, a: '{-1029, 1020, -4, 4},    e: '{-128, 127, 0, 1},   esat: 1};

    srstn       = 1'b1;
    drain_start = 1'b0;
    base_addr   = '0;
    quant_shift = '0;
    relu_en     = 1'b0;
    clear_tile();
    #2 srstn = 1'b0;
    #1 check_reset_values("reset");
    repeat (2) @(posedge clk);
    #1 srstn = 1'b1;

    $display("[TB] table-driven requantization vectors");
    for (int i = 0; i < 8; i++) begin
      clear_tile();
      for (int c = 0; c < 4; c++) begin
        tile_in[0][c]  = vecs[i].a[c];
        tile_exp[0][c] = vecs[i].e[c];
      end
      applyStimulus(i * 37, vecs[i].shift, vecs[i].relu, vecs[i].esat, 1'b0);
    end

    $display("[TB] wrapping drain with stray starts, then back-to-back drain");
    clear_tile();
    for (int r = 0; r < AS; r++)
      for (int c = 0; c < AS; c++) begin
        tile_in[r][c]  = r * 10 + c - 40;
        tile_exp[r][c] = r * 10 + c - 40;
      end
    applyStimulus(1020, 0, 1'b0, 1'b0, 1'b1);
    applyStimulus(100, 0, 1'b0, 1'b0, 1'b0);

    $display("[TB] reset in the middle of a drain");
    for (int c = 0; c < AS; c++) begin
      tile_in[0][c]  = 500;
      tile_exp[0][c] = 127;
    end
    push_expected(200);
    @(posedge clk); #1;
    base_addr   = 10'd200;
    quant_shift = 5'd0;
    relu_en     = 1'b0;
    drain_start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      drain_start = 1'b0;
    end
    @(posedge clk); #1;
    srstn = 1'b0;
    #1 check_reset_values("midreset");
    sb.delete();
    seen_wen  = 1'b0;
    seen_done = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      if (c == 2) srstn = 1'b1;
      @(negedge clk);
      seen_wen  = seen_wen  | sram_wen;
      seen_done = seen_done | drain_done;
    end
    checkOutput("wen_after_reset",  64'(seen_wen),  64'd0);
    checkOutput("done_after_reset", 64'(seen_done), 64'd0);
    checkOutput("busy_after_reset", 64'(drain_busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule

// File: doc/systolic_writeback.md
# systolic_writeback

Drain-and-requantize stage directly downstream of the systolic array. Once a tile's accumulation is finished, it walks `matrix_index` over the array rows and captures each combinational `mul_outcome` row. Each row is rounded, arithmetically shifted, optionally ReLU'd and saturated to `DATA_WIDTH`, then written as one packed word into the output SRAM. One drain per tile; consecutive tiles are placed by a caller-supplied base address.

## Interface
- `ARRAY_SIZE`, 8: rows/columns of the array; rows drained per tile.
- `DATA_WIDTH`, 8: signed output element width.
- `K_ACCUM_DEPTH`, 8: accumulation depth of the upstream array.
- `OUTCOME_WIDTH`, derived: `2*DATA_WIDTH + (K_ACCUM_DEPTH==1 ? 0 : $clog2(K_ACCUM_DEPTH)) + 1` (20 at defaults). This is the width of one accumulator.
- `ADDR_WIDTH`, 10: output SRAM address width.
- `clk` in 1: single clock, rising edge.
- `srstn` in 1: reset, asynchronous assert, active-low.
- `drain_start` in 1: single-cycle request to drain the current tile.
- `base_addr` in ADDR_WIDTH: SRAM address of row 0. Latched on an accepted start.
- `quant_shift` in 5: right-shift amount, 0..OUTCOME_WIDTH-1. Latched on an accepted start.
- `relu_en` in 1: clamp negatives to 0. Latched on an accepted start.
- `mul_outcome` in ARRAY_SIZE*OUTCOME_WIDTH: row selected by `matrix_index`. Column j sits at `[j*OUTCOME_WIDTH +: OUTCOME_WIDTH]`. Combinational from the array's registers.
- `matrix_index` out 6: row select to the array.
- `sram_wen` out 1: output SRAM write enable, active-high.
- `sram_waddr` out ADDR_WIDTH: write address.
- `sram_wdata` out ARRAY_SIZE*DATA_WIDTH: packed row. Element j at `[j*DATA_WIDTH +: DATA_WIDTH]`.
- `drain_busy` out 1: high from the cycle after an accepted start through the last write.
- `drain_done` out 1: one-cycle pulse after the last write.
- `sat_flag` out 1: sticky. Set if any element of the current drain saturated; cleared on the next accepted start.

## Operation
- FSM states: IDLE, DRAIN, FLUSH, DONE.
- IDLE: `drain_start` accepted → latch `base_addr`, `quant_shift`, `relu_en`; clear the row counter and `sat_flag`; go to DRAIN.
- `drain_start` while not IDLE is ignored. No queuing.
- DRAIN: `matrix_index` = row counter r (0..ARRAY_SIZE-1), one row per cycle.
  - `mul_outcome` is captured and requantized at the end of the same cycle into the write register.
  - After r = ARRAY_SIZE-1 → FLUSH.
- FLUSH: the last write is presented; go to DONE.
- DONE: pulse `drain_done`; go to IDLE.
- Precondition: the array's `alu_start` is low for the whole drain so that accumulators hold. The caller guarantees this.
- Requantize, per element `a` (signed, OUTCOME_WIDTH), in OUTCOME_WIDTH+1 bits so nothing overflows:
  - s = 0: t = a.
  - s > 0: t = (a + 2^(s-1)) >>> s. This is round-half-up.
  - ReLU: if `relu_en` and t < 0, then t = 0.
  - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. Any clipping sets `sat_flag`.
  - Values of `quant_shift` ≥ OUTCOME_WIDTH are treated as OUTCOME_WIDTH-1.
- Address for row r = `base_addr` + r, modulo 2^ADDR_WIDTH (wraps).

## Timing
- Accepted start at cycle 0.
- `matrix_index` = r during cycle r+1.
- Row r write (`sram_wen`=1, address, data) in cycle r+2.
- Last write in cycle ARRAY_SIZE+1.
- `drain_done` in cycle ARRAY_SIZE+2; `drain_busy` is low in that cycle.
- Earliest next accepted start: cycle ARRAY_SIZE+3 (FSM back in IDLE).
- All outputs are registered. `sram_wen` is never high outside the write cycles.
- Reset values: `matrix_index`=0, `sram_wen`=0, `sram_waddr`=0, `sram_wdata`=0, `drain_busy`=0, `drain_done`=0, `sat_flag`=0; FSM in IDLE.
- Reset mid-drain: everything clears immediately and no further write is issued for that tile.
- `drain_start` in the same cycle as DONE is ignored. The FSM is not yet in IDLE.

## Structure
- Shared package `systolic_pkg` holds:
  - `OUTCOME_WIDTH` derivation function;
  - FSM state enum;
  - saturation bounds as functions of DATA_WIDTH.
- One sub-module, `requant_lane`, purely combinational: one accumulator in, `quant_shift`/`relu_en` in, DATA_WIDTH result plus saturation bit out.
  - Instantiated ARRAY_SIZE times.
  - The top level owns the FSM, counters, latches and output registers.

## Test plan
All cases use default parameters (OUTCOME_WIDTH=20).
- Shift 0, no ReLU, row 0 = {100, 300, -300, 0,…}: write data {100, 127, -128, 0,…}; `sat_flag`=1.
- Shift 4, row elements {40, -40, 8, -8}: results {3, -2, 1, 0}; `sat_flag`=0.
- ReLU on, shift 0, {-5, 5}: results {0, 5}.
- Base 1020, start at cycle 0:
  - writes to 1020, 1021, 1022, 1023, 0, 1, 2, 3 in cycles 2..9;
  - `matrix_index` 0..7 in cycles 1..8;
  - `drain_done` in cycle 10.
- Extra `drain_start` pulses in cycles 3 and 10: both ignored, exactly 8 writes. A pulse in cycle 11 starts a new drain.
- `srstn` low in cycle 5 of a drain: all outputs go to reset values asynchronously; no `sram_wen` or `drain_done` follows.
